apb_master: RTL and testbench

Single-outstanding APB initiator that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers toward the encoder/decoder register block (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE). It sits between the test/host sequencer and the APB register slave. It returns one response per command: read data or write acknowledge, plus an error flag. A wait-state timeout keeps a stuck slave from hanging the host.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_wait_timer.sv | 34 +++
 rtl/apb_master.sv | 134 +++++++++++++
 tb/tb_apb_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM state encoding, default bus
// widths and the register map of the encoder/decoder register block.
package apb_pkg;

   localparam int unsigned DEFAULT_AMBA_WORD       = 32;
   localparam int unsigned DEFAULT_AMBA_ADDR_WIDTH = 20;

   // Register block byte offsets
   localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ADDR_CTRL           = 20'h0;
   localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN        = 20'h4;
   localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ADDR_CODEWORD_WIDTH = 20'h8;
   localparam logic [DEFAULT_AMBA_ADDR_WIDTH-1:0] ADDR_NOISE          = 20'hC;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter.
//   clk, rst   : clock, synchronous active-low reset
//   clr        : zero the counter (priority over en)
//   en         : count one wait cycle
//   expired_c  : counter has reached TIMEOUT_CYCLES (decoded from the register)
module apb_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count;

   // Saturates at LIMIT so a long-stuck slave never wraps the count
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired_c = (count == LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: turns valid/ready commands into APB
// SETUP/ACCESS transfers and returns one response pulse per command.
//   cmd_*      : host command channel (cmd_ready decoded from state and PREADY)
//   rsp_*      : one-cycle response (read data / write ack, error flag)
//   P*         : APB initiator signals toward the register slave
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned AMBA_WORD       = DEFAULT_AMBA_WORD,
   parameter int unsigned AMBA_ADDR_WIDTH = DEFAULT_AMBA_ADDR_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AMBA_WORD-1:0]       cmd_wdata,
   output logic                       rsp_valid,
   output logic [AMBA_WORD-1:0]       rsp_rdata,
   output logic                       rsp_err,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   input  logic [AMBA_WORD-1:0]       PRDATA,
   input  logic                       PREADY
);

   apb_state_t state;
   logic       aligned;
   logic       accept;
   logic       start;
   logic       wait_en;
   logic       expired;

   assign aligned = (cmd_addr[1:0] == 2'b00);

   // A misaligned command is not taken on a completion cycle: its error pulse
   // would collide with the completing transfer's response. It is taken in IDLE.
   always_comb begin
      cmd_ready = 1'b0;
      if (rst) begin
         case (state)
            IDLE:    cmd_ready = 1'b1;
            ACCESS:  cmd_ready = PREADY && aligned;
            default: cmd_ready = 1'b0;
         endcase
      end
   end

   assign accept  = cmd_valid && cmd_ready;
   assign start   = accept && aligned;
   assign wait_en = (state == ACCESS) && !PREADY;

   apb_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr       (start),
      .en        (wait_en),
      .expired_c (expired)
   );

   // FSM with registered APB and response outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  PADDR   <= cmd_addr;
                  PWRITE  <= cmd_write;
                  PWDATA  <= cmd_wdata;
                  PSEL    <= 1'b1;
                  PENABLE <= 1'b0;
                  state   <= SETUP;
               end else if (accept) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               // Completion has priority over a timeout in the same cycle
               if (PREADY) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  PENABLE   <= 1'b0;
                  if (start) begin
                     PADDR  <= cmd_addr;
                     PWRITE <= cmd_write;
                     PWDATA <= cmd_wdata;
                     state  <= SETUP;
                  end else begin
                     PSEL  <= 1'b0;
                     state <= IDLE;
                  end
               end else if (expired) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: table of single-command vectors plus
// hand-written back-to-back, reset-state and reset-mid-transfer sequences.
module tb_apb_master;
   import apb_pkg::*;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [19:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [19:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   int checks;
   int failures;

   apb_master #(
      .AMBA_WORD(32),
      .AMBA_ADDR_WIDTH(20),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // waits: ACCESS cycles with PREADY=0 before the ready cycle
   // bus:   a SETUP/ACCESS transfer is expected
   // lat:   cycles after the handshake edge until rsp_valid is visible
   typedef struct {
      logic        write;
      logic [19:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        bus;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command from IDLE and check every cycle until one past the response
   task automatic run_vec(input int idx, input vec_t v);
      string tag;
      logic  exp_ready;
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      #1;
      check($sformatf("v%0d idle_ready", idx), 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      for (int j = 0; j <= v.exp_lat + 1; j++) begin
         if (j > 0) tick();
         tag = $sformatf("v%0d j%0d", idx, j);
         check({tag, " psel"}, 32'(PSEL), 32'(v.bus && (j < v.exp_lat)));
         check({tag, " penable"}, 32'(PENABLE), 32'(v.bus && (j >= 1) && (j < v.exp_lat)));
         check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(j == v.exp_lat));
         if (j == v.exp_lat) begin
            check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
            check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
         end
         if (v.bus && (j < v.exp_lat)) begin
            check({tag, " paddr"}, 32'(PADDR), 32'(v.addr));
            check({tag, " pwrite"}, 32'(PWRITE), 32'(v.write));
            if (v.write) check({tag, " pwdata"}, PWDATA, v.wdata);
         end
         PREADY = v.bus && (j == 1 + v.waits);
         PRDATA = PREADY ? v.prdata : (32'hBAD0_0000 | 32'(j));
         exp_ready = (!v.bus || (j >= v.exp_lat)) ? 1'b1 : (j == 1 + v.waits);
         #1;
         check({tag, " cmd_ready"}, 32'(cmd_ready), 32'(exp_ready));
      end
      PREADY = 1'b0;
   endtask

   logic exp_psel[5];
   logic exp_pen[5];
   logic exp_rv[5];
   logic [19:0] exp_paddr[4];

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 20'h4;
      cmd_wdata = 32'h1111_2222;
      PRDATA    = 32'h0;
      PREADY    = 1'b1;

      //                 write addr                 wdata          waits prdata        bus exp_rdata     err lat
      vecs[0] = '{1'b1, ADDR_CTRL,           32'h0000_0001, 0,    32'h7777_7777, 1'b1, 32'h0,         1'b0, 2};
      vecs[1] = '{1'b0, ADDR_NOISE,          32'h0,         3,    32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0, 5};
      vecs[2] = '{1'b1, ADDR_DATA_IN,        32'hA5A5_5A5A, 1,    32'h0000_1234, 1'b1, 32'h0,         1'b0, 3};
      vecs[3] = '{1'b0, ADDR_CODEWORD_WIDTH, 32'h0,         0,    32'h0000_0020, 1'b1, 32'h0000_0020, 1'b0, 2};
      vecs[4] = '{1'b1, 20'h6,               32'h0000_00FF, 0,    32'h5555_5555, 1'b0, 32'h0,         1'b1, 0};
      vecs[5] = '{1'b0, 20'h3,               32'h0,         0,    32'h5555_5555, 1'b0, 32'h0,         1'b1, 0};
      vecs[6] = '{1'b0, ADDR_NOISE,          32'h0,         1000, 32'h0,         1'b1, 32'h0,         1'b1, 18};
      vecs[7] = '{1'b0, ADDR_CTRL,           32'h0,         16,   32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0, 18};
      vecs[8] = '{1'b0, ADDR_DATA_IN,        32'h0,         15,   32'h0BAD_C0DE, 1'b1, 32'h0BAD_C0DE, 1'b0, 17};
      vecs[9] = '{1'b1, 20'hFFFFC,           32'h8000_0001, 2,    32'h1, 1'b1, 32'h0,         1'b0, 4};

      // Reset state, with a command offered during reset
      tick();
      tick();
      check("rst cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst psel", 32'(PSEL), 32'd0);
      check("rst penable", 32'(PENABLE), 32'd0);
      check("rst pwrite", 32'(PWRITE), 32'd0);
      check("rst paddr", 32'(PADDR), 32'd0);
      check("rst pwdata", PWDATA, 32'd0);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rsp_rdata", rsp_rdata, 32'd0);
      check("rst rsp_err", 32'(rsp_err), 32'd0);
      cmd_valid = 1'b0;
      PREADY    = 1'b0;
      rst       = 1'b1;
      tick();
      check("post_rst psel", 32'(PSEL), 32'd0);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Back-to-back zero-wait writes to DATA_IN then CODEWORD_WIDTH
      exp_psel  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_pen   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_rv    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_paddr = '{ADDR_DATA_IN, ADDR_DATA_IN, ADDR_CODEWORD_WIDTH, ADDR_CODEWORD_WIDTH};
      PREADY    = 1'b1;
      PRDATA    = 32'h0000_0055;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = ADDR_DATA_IN;
      cmd_wdata = 32'h0000_0A0A;
      tick();
      cmd_addr  = ADDR_CODEWORD_WIDTH;
      cmd_wdata = 32'h0000_0B0B;
      for (int j = 0; j < 5; j++) begin
         if (j > 0) tick();
         if (j == 2) cmd_valid = 1'b0;
         check($sformatf("b2b j%0d psel", j), 32'(PSEL), 32'(exp_psel[j]));
         check($sformatf("b2b j%0d penable", j), 32'(PENABLE), 32'(exp_pen[j]));
         check($sformatf("b2b j%0d rsp_valid", j), 32'(rsp_valid), 32'(exp_rv[j]));
         if (exp_rv[j]) begin
            check($sformatf("b2b j%0d rsp_rdata", j), rsp_rdata, 32'h0);
            check($sformatf("b2b j%0d rsp_err", j), 32'(rsp_err), 32'h0);
         end
         if (j < 4) begin
            check($sformatf("b2b j%0d paddr", j), 32'(PADDR), 32'(exp_paddr[j]));
            check($sformatf("b2b j%0d pwdata", j), PWDATA, (j < 2) ? 32'h0000_0A0A : 32'h0000_0B0B);
         end
      end
      PREADY = 1'b0;
      tick();
      check("b2b idle rsp_valid", 32'(rsp_valid), 32'd0);

      // Reset during ACCESS wait states: transfer dropped, no response
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = ADDR_CODEWORD_WIDTH;
      cmd_wdata = 32'h1234_5678;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      check("rstmid in_access penable", 32'(PENABLE), 32'd1);
      rst = 1'b0;
      #1;
      check("rstmid cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
      check("rstmid psel", 32'(PSEL), 32'd0);
      check("rstmid penable", 32'(PENABLE), 32'd0);
      check("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
      check("rstmid paddr", 32'(PADDR), 32'd0);
      rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         check($sformatf("rstmid quiet%0d rsp_valid", j), 32'(rsp_valid), 32'd0);
         check($sformatf("rstmid quiet%0d psel", j), 32'(PSEL), 32'd0);
      end
      run_vec(10, vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
